// File: rtl/usb20sr_refdes_rst_ctrl_pio.sv
// rtl/usb20sr_refdes_rst_ctrl_pio.sv - Avalon-MM output PIO with set/clear registers and timed pulse engine
module usb20sr_refdes_rst_ctrl_pio #(
    parameter int                     WIDTH         = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE   = {WIDTH{1'b1}},
    parameter int                     PULSE_CNT_W   = 16,
    parameter logic [PULSE_CNT_W-1:0] PULSE_DEFAULT = 16'd100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       data_q;
    logic [WIDTH-1:0]       mask_q;
    logic [PULSE_CNT_W-1:0] len_q;
    logic [PULSE_CNT_W-1:0] cnt_q;
    logic                   done_q;
    logic                   irq_en_q;

    logic                   wr;
    logic [WIDTH-1:0]       wd;
    logic [PULSE_CNT_W-1:0] wlen;
    logic                   pulse_go;
    logic                   pulse_end;
    logic                   done_w1c;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign wlen      = writedata[PULSE_CNT_W-1:0];
    // A pulse only starts from idle with a non-empty mask and a non-zero length
    assign pulse_go  = wr && (address == 3'd4) && (state == S_IDLE)
                       && (wd != '0) && (len_q != '0);
    assign pulse_end = (state == S_ACTIVE) && (cnt_q == PULSE_CNT_W'(1));
    assign done_w1c  = wr && (address == 3'd5) && writedata[1];

    assign out_port  = data_q ^ mask_q;
    assign irq       = done_q & irq_en_q;

    // Register file, pulse FSM and sticky done flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            len_q    <= PULSE_DEFAULT;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    3'd0:    data_q   <= wd;
                    3'd1:    data_q   <= data_q | wd;
                    3'd2:    data_q   <= data_q & ~wd;
                    3'd3:    len_q    <= wlen;
                    3'd5:    irq_en_q <= writedata[2];
                    default: ;
                endcase
            end

            // Completion beats a simultaneous write-1-clear
            if (pulse_end) begin
                done_q <= 1'b1;
            end else if (done_w1c) begin
                done_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pulse_go) begin
                        mask_q <= wd;
                        cnt_q  <= len_q;
                        state  <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    cnt_q <= cnt_q - PULSE_CNT_W'(1);
                    if (pulse_end) begin
                        mask_q <= '0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Zero-wait-state read mux, zero-extended to the bus width
    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[WIDTH-1:0]       = data_q;
            3'd3: readdata[PULSE_CNT_W-1:0] = len_q;
            3'd4: readdata[WIDTH-1:0]       = mask_q;
            3'd5: readdata[2:0]             = {irq_en_q, done_q, state == S_ACTIVE};
            default: ;
        endcase
    end

endmodule
